traffic_phase_sequencer: RTL and testbench

Upstream timing and request stage for the traffic-light path. It advances one signal head through the RED → RED_YELLOW → GREEN → YELLOW cycle on a slow tick enable, debounces and latches a pedestrian push-button, shortens GREEN on a pending request, and supports a night flashing-yellow mode. It drives registered lamp bits and a phase code to the downstream lamp/state-decode stage, plus a one-cycle phase-start strobe.

---
 rtl/traffic_pkg.sv | 28 ++
 rtl/ped_debounce.sv | 37 +++
 rtl/traffic_phase_sequencer.sv | 153 +++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light path (sequencer and lamp decode).
package traffic_pkg;

    typedef enum logic [2:0] {
        PH_RED     = 3'd0,
        PH_RED_YEL = 3'd1,
        PH_GREEN   = 3'd2,
        PH_YEL     = 3'd3,
        PH_FLASH   = 3'd4
    } phase_t;

    // Lamp bits are {red, yellow, green}
    localparam logic [2:0] LAMP_RED     = 3'b100;
    localparam logic [2:0] LAMP_RED_YEL = 3'b110;
    localparam logic [2:0] LAMP_GREEN   = 3'b001;
    localparam logic [2:0] LAMP_YEL     = 3'b010;
    localparam logic [2:0] LAMP_OFF     = 3'b000;

    // Default phase durations in ticks
    localparam int DEF_T_RED       = 8;
    localparam int DEF_T_RED_YEL   = 1;
    localparam int DEF_T_GREEN     = 7;
    localparam int DEF_T_GREEN_MIN = 3;
    localparam int DEF_T_YEL       = 2;
    localparam int DEF_DEB_N       = 4;
    localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/ped_debounce.sv
// Pedestrian button debouncer: one-clk pulse after DEB_N consecutive high samples,
// re-armed only once the button has been seen low again.
module ped_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_N = DEF_DEB_N
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press_pulse
);

    localparam int CW = $clog2(DEB_N + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive high samples, saturating at DEB_N so the pulse cannot repeat
    always_comb begin
        cnt_d = cnt_q;
        if (!btn) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEB_N)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Pulse coincides with the edge that takes the DEB_N-th high sample
    assign press_pulse = btn && (cnt_q == CW'(DEB_N - 1));

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Phase timing and pedestrian request stage: steps RED/RED_YEL/GREEN/YEL on tick,
// shortens GREEN for a pending request, and offers a flashing-yellow night mode.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int T_RED       = DEF_T_RED,
    parameter int T_RED_YEL   = DEF_T_RED_YEL,
    parameter int T_GREEN     = DEF_T_GREEN,
    parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
    parameter int T_YEL       = DEF_T_YEL,
    parameter int DEB_N       = DEF_DEB_N,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_btn,
    input  logic       night_mode,
    output logic [2:0] phase,
    output logic [2:0] lamp,
    output logic       walk,
    output logic       ped_pending,
    output logic       phase_start
);

    // GREEN may be cut once elapsed ticks reach T_GREEN_MIN, i.e. timer <= this value
    localparam logic [CNT_W-1:0] CUT_AT = CNT_W'(T_GREEN - T_GREEN_MIN + 1);

    phase_t             phase_q, phase_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               flash_q, flash_d;
    logic [2:0]         lamp_q, lamp_d;
    logic               walk_q, walk_d;
    logic               ped_q, ped_d;
    logic               start_q, start_d;
    logic               press;
    logic               serve;

    ped_debounce #(.DEB_N(DEB_N)) u_deb (
        .clk         (clk),
        .rst         (rst),
        .btn         (ped_btn),
        .press_pulse (press)
    );

    // State register: every output is registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_RED;
            timer_q <= CNT_W'(T_RED);
            flash_q <= 1'b0;
            lamp_q  <= LAMP_RED;
            walk_q  <= 1'b0;
            ped_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            flash_q <= flash_d;
            lamp_q  <= lamp_d;
            walk_q  <= walk_d;
            ped_q   <= ped_d;
            start_q <= start_d;
        end
    end

    // Next phase and timer: only ticks advance; timer==1 means this is the last tick
    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        flash_d = flash_q;
        if (tick) begin
            case (phase_q)
                PH_RED: begin
                    if (timer_q == CNT_W'(1)) begin
                        if (night_mode) begin
                            phase_d = PH_FLASH;
                            flash_d = 1'b1;
                        end else begin
                            phase_d = PH_RED_YEL;
                            timer_d = CNT_W'(T_RED_YEL);
                        end
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                PH_RED_YEL: begin
                    if (timer_q == CNT_W'(1)) begin
                        phase_d = PH_GREEN;
                        timer_d = CNT_W'(T_GREEN);
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                PH_GREEN: begin
                    if (timer_q == CNT_W'(1) || (ped_q && timer_q <= CUT_AT)) begin
                        phase_d = PH_YEL;
                        timer_d = CNT_W'(T_YEL);
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                PH_YEL: begin
                    if (timer_q == CNT_W'(1)) begin
                        phase_d = PH_RED;
                        timer_d = CNT_W'(T_RED);
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                PH_FLASH: begin
                    if (!night_mode) begin
                        phase_d = PH_RED;
                        timer_d = CNT_W'(T_RED);
                        flash_d = 1'b0;
                    end else begin
                        flash_d = ~flash_q;
                    end
                end
                default: begin
                    phase_d = PH_RED;
                    timer_d = CNT_W'(T_RED);
                    flash_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs for the next cycle: lamps, walk/request handshake, phase-start strobe
    always_comb begin
        serve = tick && (phase_q == PH_YEL) && (phase_d == PH_RED) && ped_q;
        case (phase_d)
            PH_RED:     lamp_d = LAMP_RED;
            PH_RED_YEL: lamp_d = LAMP_RED_YEL;
            PH_GREEN:   lamp_d = LAMP_GREEN;
            PH_YEL:     lamp_d = LAMP_YEL;
            PH_FLASH:   lamp_d = flash_d ? LAMP_YEL : LAMP_OFF;
            default:    lamp_d = LAMP_RED;
        endcase
        // walk lives only inside the RED that served a request
        walk_d  = (phase_d == PH_RED) && (serve || walk_q);
        // a fresh press wins over the clear so it is not lost at serve time
        ped_d   = press ? 1'b1 : (serve ? 1'b0 : ped_q);
        start_d = (phase_d != phase_q);
    end

    assign phase       = phase_q;
    assign lamp        = lamp_q;
    assign walk        = walk_q;
    assign ped_pending = ped_q;
    assign phase_start = start_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Scenario bench for traffic_phase_sequencer with a queue of expected output snapshots.
module tb_traffic_phase_sequencer;
    import traffic_pkg::*;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] lamp;
        logic       walk;
        logic       ped;
        logic       start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_btn = 1'b0;
    logic       night_mode = 1'b0;
    logic [2:0] phase, lamp;
    logic       walk, ped_pending, phase_start;

    exp_t sb[$];
    exp_t plan[$];
    exp_t obs;
    int   nchk = 0;
    int   nerr = 0;

    assign obs = exp_t'({phase, lamp, walk, ped_pending, phase_start});

    traffic_phase_sequencer #(
        .T_RED(8), .T_RED_YEL(1), .T_GREEN(7), .T_GREEN_MIN(3), .T_YEL(2),
        .DEB_N(4), .CNT_W(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .ped_btn     (ped_btn),
        .night_mode  (night_mode),
        .phase       (phase),
        .lamp        (lamp),
        .walk        (walk),
        .ped_pending (ped_pending),
        .phase_start (phase_start)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2:0] lamp_of(logic [2:0] ph, logic lit);
        case (ph)
            3'd0:    return 3'b100;
            3'd1:    return 3'b110;
            3'd2:    return 3'b001;
            3'd3:    return 3'b010;
            default: return lit ? 3'b010 : 3'b000;
        endcase
    endfunction

    function automatic exp_t mk(logic [2:0] ph, logic lit, logic w, logic p, logic s);
        exp_t x;
        x.ph = ph; x.lamp = lamp_of(ph, lit); x.walk = w; x.ped = p; x.start = s;
        return x;
    endfunction

    // Phase held after k ticks of a plain cycle from a fresh RED (RED 8, RY 1, G 7, Y 2)
    function automatic logic [2:0] seq_at(int k);
        if (k < 8)  return 3'd0;
        if (k < 9)  return 3'd1;
        if (k < 16) return 3'd2;
        return 3'd3;
    endfunction

    function automatic string fmt(exp_t x);
        return $sformatf("ph=%0d lamp=%b walk=%b ped=%b start=%b", x.ph, x.lamp, x.walk, x.ped, x.start);
    endfunction

    task automatic clk1();
        @(posedge clk); #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1; clk1(); tick = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1; tick = 1'b0;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        clk1(); clk1();
        e = sb.pop_front();
        nchk++;
        if (obs !== e) begin nerr++; $display("FAIL reset: got %s want %s", fmt(obs), fmt(e)); end
        rst = 1'b0;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        clk1();
        e = sb.pop_front();
        nchk++;
        if (obs !== e) begin nerr++; $display("FAIL reset_idle: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_normal_cycle();
        exp_t e;
        logic [2:0] nxt, prv;
        int pulses;
        pulses = 0;
        for (int i = 1; i <= 18; i++) begin
            nxt = seq_at(i % 18);
            prv = seq_at(i - 1);
            sb.push_back(mk(nxt, 1'b0, 1'b0, 1'b0, nxt != prv));
            pulse_tick();
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL normal[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
            pulses += int'(phase_start);
            repeat (3) begin clk1(); pulses += int'(phase_start); end
        end
        nchk++;
        if (pulses != 4) begin nerr++; $display("FAIL normal_pulses: got %0d want 4", pulses); end
    endtask

    task automatic test_debounce_short();
        exp_t e;
        for (int k = 1; k <= 4; k++) begin
            ped_btn = (k <= 3);
            sb.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
            clk1();
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL deb_short[%0d]: got %s want %s", k, fmt(obs), fmt(e)); end
        end
        ped_btn = 1'b0;
    endtask

    task automatic test_ped_cut();
        exp_t e;
        plan.delete();
        for (int i = 1; i <= 9; i++)
            plan.push_back(mk((i < 8) ? 3'd0 : ((i == 8) ? 3'd1 : 3'd2), 1'b0, 1'b0, 1'b0, i >= 8));
        plan.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0));   // GREEN tick 1
        plan.push_back(mk(3'd2, 1'b0, 1'b0, 1'b1, 1'b0));   // GREEN tick 2
        plan.push_back(mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b1));   // tick 3: cut to YEL
        plan.push_back(mk(3'd3, 1'b0, 1'b0, 1'b1, 1'b0));
        plan.push_back(mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b1));   // served at RED entry
        for (int i = 0; i < 7; i++) plan.push_back(mk(3'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        plan.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < plan.size(); i++) begin
            if (i == 10) begin
                // qualify a press between GREEN tick 1 and tick 2
                ped_btn = 1'b1;
                for (int k = 1; k <= 4; k++) begin
                    sb.push_back(mk(3'd2, 1'b0, 1'b0, k == 4, 1'b0));
                    clk1();
                    e = sb.pop_front();
                    nchk++;
                    if (obs !== e) begin nerr++; $display("FAIL deb_press[%0d]: got %s want %s", k, fmt(obs), fmt(e)); end
                end
                ped_btn = 1'b0;
            end
            sb.push_back(plan[i]);
            pulse_tick();
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL ped_cut[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
            clk1();
        end
    endtask

    task automatic test_night();
        exp_t e;
        plan.delete();
        plan.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 6; i++) plan.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b1));
        plan.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < 7; i++) plan.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b1));   // FLASH, starts lit
        plan.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(3'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b1));   // leave FLASH
        for (int i = 0; i < 7; i++) plan.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        plan.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b1));
        for (int i = 0; i < plan.size(); i++) begin
            if (i == 1)  night_mode = 1'b1;
            if (i == 21) night_mode = 1'b0;
            sb.push_back(plan[i]);
            pulse_tick();
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL night[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
            clk1();
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        sb.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 2; i++) begin
            pulse_tick();
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL rmid_green[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
        end
        ped_btn = 1'b1;
        repeat (4) clk1();
        nchk++;
        if (ped_pending !== 1'b1) begin nerr++; $display("FAIL rmid_pending: got %b want 1", ped_pending); end
        // reset together with a tick: reset must win
        ped_btn = 1'b0; rst = 1'b1; tick = 1'b1;
        sb.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        clk1();
        rst = 1'b0; tick = 1'b0;
        e = sb.pop_front();
        nchk++;
        if (obs !== e) begin nerr++; $display("FAIL rmid_reset: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0] nxt, prv;
        tick = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            nxt = seq_at(i % 18);
            prv = seq_at(i - 1);
            sb.push_back(mk(nxt, 1'b0, 1'b0, 1'b0, nxt != prv));
            clk1();
            e = sb.pop_front();
            nchk++;
            if (obs !== e) begin nerr++; $display("FAIL b2b[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
        end
        tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_debounce_short();
        test_ped_cut();
        test_night();
        test_reset_mid();
        test_back_to_back();
        nchk++;
        if (sb.size() != 0) begin nerr++; $display("FAIL scoreboard_left: got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
